// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one imem request in flight,
// and buffers returned words in an output slot plus a single skid (hold) entry.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   localparam entry_t EMPTY = '{valid: 1'b0, pc: 32'h0, instr: NOP};

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_pc, req_pc_n;
   logic        discard, discard_n;
   entry_t      slot, slot_n;
   entry_t      hold, hold_n;
   logic        consume;
   logic        slot_free;

   assign consume   = slot.valid & ~stall;
   assign slot_free = ~slot.valid | consume;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign if_valid  = slot.valid;
   assign if_pc     = slot.pc;
   assign if_instr  = slot.instr;

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      req_pc_n  = req_pc;
      discard_n = discard;
      slot_n    = consume ? EMPTY : slot;
      hold_n    = hold;

      case (state)
         IDLE:  state_n = FETCH;
         FETCH: begin
            req_pc_n = pc;
            pc_n     = pc + 32'd4;
            state_n  = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (discard) begin
                  discard_n = 1'b0;
                  state_n   = FETCH;
               end else if (slot_free) begin
                  slot_n  = '{valid: 1'b1, pc: req_pc, instr: imem_rdata};
                  state_n = FETCH;
               end else begin
                  hold_n  = '{valid: 1'b1, pc: req_pc, instr: imem_rdata};
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               slot_n       = hold;
               hold_n.valid = 1'b0;
               state_n      = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase

      // A request issued in FETCH is already accepted by memory, so its
      // response must still be waited for and dropped.
      if (redirect && state != IDLE) begin
         pc_n         = redirect_pc & ~32'h3;
         slot_n       = EMPTY;
         hold_n.valid = 1'b0;
         case (state)
            FETCH: begin
               discard_n = 1'b1;
               state_n   = WAIT;
            end
            WAIT: begin
               discard_n = ~imem_rvalid;
               state_n   = imem_rvalid ? FETCH : WAIT;
            end
            HOLD:    state_n = FETCH;
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         req_pc  <= RESET_PC;
         discard <= 1'b0;
         slot    <= EMPTY;
         hold    <= EMPTY;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         req_pc  <= req_pc_n;
         discard <= discard_n;
         slot    <= slot_n;
         hold    <= hold_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable imem model, request and
// output scoreboards, plus a second instance exercising PC wrap at 0xFFFFFFFC.
module tb_fetch_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk, reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_rvalid, if_valid;
   logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;

   logic        w_stall, w_redirect, w_req, w_rvalid, w_if_valid;
   logic [31:0] w_redirect_pc, w_addr, w_rdata, w_if_pc, w_if_instr;

   logic        mem_auto, m_rvalid, m_busy, man_rvalid, mon_en;
   logic [31:0] m_rdata, m_addr, man_rdata;
   int          m_cnt, mem_lat, cur;
   int          n_chk, n_err;

   logic [31:0] req_q[$];
   exp_t        slot_q[$];

   assign imem_rvalid = mem_auto ? m_rvalid : man_rvalid;
   assign imem_rdata  = mem_auto ? m_rdata  : man_rdata;

   fetch_stage u_dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .stall(w_stall), .redirect(w_redirect),
      .redirect_pc(w_redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic to_cyc(input int n);
      while (cur < n) begin
         @(posedge clk);
         cur++;
      end
      #1;
   endtask

   task automatic push_slot(input logic [31:0] p);
      slot_q.push_back('{pc: p, instr: word(p)});
   endtask

   task automatic end_test();
      @(posedge clk);
      chk("req_q_drain", req_q.size(), 0);
      chk("slot_q_drain", slot_q.size(), 0);
      req_q.delete();
      slot_q.delete();
      #1 reset = 1'b1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      cur = 0;
   endtask

   // imem model: one outstanding request, response mem_lat cycles later
   initial forever begin
      @(negedge clk);
      if (reset || !mem_auto) begin
         m_busy   = 1'b0;
         m_rvalid = 1'b0;
      end else begin
         m_rvalid = 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               m_rvalid = 1'b1;
               m_rdata  = word(m_addr);
               m_busy   = 1'b0;
            end else m_cnt--;
         end else if (imem_req) begin
            m_busy = 1'b1;
            m_cnt  = mem_lat;
            m_addr = imem_addr;
         end
      end
   end

   // scoreboards: issued addresses and consumed slot contents
   initial forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
         if (imem_req) begin
            chk("req_expected", {31'b0, req_q.size() != 0}, 32'h1);
            if (req_q.size() != 0) chk("req_addr", imem_addr, req_q.pop_front());
         end
         if (if_valid && !stall && !redirect) begin
            chk("slot_expected", {31'b0, slot_q.size() != 0}, 32'h1);
            if (slot_q.size() != 0) begin
               exp_t e;
               e = slot_q.pop_front();
               chk("slot_pc", if_pc, e.pc);
               chk("slot_instr", if_instr, e.instr);
            end
         end else if (!if_valid) begin
            chk("empty_instr_nop", if_instr, NOP);
            chk("empty_pc_zero", if_pc, 32'h0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0; cur = 0;
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      mem_auto = 1'b1; mem_lat = 1; man_rvalid = 1'b0; man_rdata = 32'h0;
      m_rdata = 32'h0; m_addr = 32'h0; m_cnt = 0; mon_en = 1'b0;
      w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
      w_rvalid = 1'b0; w_rdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_instr", if_instr, NOP);

      // straight-line fetch at 1-cycle latency
      mon_en = 1'b1;
      req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      push_slot(32'h0); push_slot(32'h4); push_slot(32'h8);
      release_reset();
      for (int c = 1; c <= 7; c++) begin
         to_cyc(c);
         @(negedge clk);
         chk("t1_req", imem_req, c % 2);
         if (c % 2 == 1) chk("t1_addr", imem_addr, 2 * (c - 1));
         if (c >= 3) chk("t1_valid", if_valid, c % 2);
      end
      to_cyc(8);
      @(negedge clk);

      // stall with a response arriving into the hold entry
      end_test();
      req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      push_slot(32'h0); push_slot(32'h4); push_slot(32'h8); push_slot(32'hC);
      release_reset();
      to_cyc(5);
      stall = 1'b1;
      for (int c = 5; c <= 9; c++) begin
         to_cyc(c);
         @(negedge clk);
         chk("t2_frozen_valid", if_valid, 1'b1);
         chk("t2_frozen_pc", if_pc, 32'h4);
         chk("t2_frozen_instr", if_instr, word(32'h4));
         if (c >= 6) chk("t2_no_req", imem_req, 1'b0);
      end
      to_cyc(10);
      stall = 1'b0;
      @(negedge clk);
      chk("t2_hold_no_req", imem_req, 1'b0);
      to_cyc(11);
      @(negedge clk);
      chk("t2_from_hold_pc", if_pc, 32'h8);
      chk("t2_resume_req", imem_req, 1'b1);
      chk("t2_resume_addr", imem_addr, 32'hC);
      to_cyc(13);
      @(negedge clk);

      // redirect while waiting on a 3-cycle response
      end_test();
      mem_lat = 3;
      req_q = '{32'h0, 32'h100, 32'h104};
      push_slot(32'h100);
      release_reset();
      to_cyc(2);
      redirect = 1'b1; redirect_pc = 32'h100;
      to_cyc(3);
      redirect = 1'b0;
      @(negedge clk);
      chk("t3_addr_redir", imem_addr, 32'h100);
      chk("t3_wait_no_req", imem_req, 1'b0);
      to_cyc(5);
      @(negedge clk);
      chk("t3_req", imem_req, 1'b1);
      chk("t3_req_addr", imem_addr, 32'h100);
      to_cyc(9);
      @(negedge clk);
      chk("t3_valid", if_valid, 1'b1);
      chk("t3_pc", if_pc, 32'h100);

      // redirect and stall together on a valid slot; low bits masked
      end_test();
      mem_lat = 1;
      req_q = '{32'h0, 32'h4, 32'h200, 32'h204};
      push_slot(32'h200);
      release_reset();
      to_cyc(3);
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      chk("t4_pre_valid", if_valid, 1'b1);
      chk("t4_pre_pc", if_pc, 32'h0);
      to_cyc(4);
      stall = 1'b0; redirect = 1'b0;
      @(negedge clk);
      chk("t4_flushed", if_valid, 1'b0);
      chk("t4_flush_nop", if_instr, NOP);
      chk("t4_addr", imem_addr, 32'h200);
      to_cyc(5);
      @(negedge clk);
      chk("t4_req", imem_req, 1'b1);
      chk("t4_req_addr", imem_addr, 32'h200);
      to_cyc(7);
      @(negedge clk);
      chk("t4_valid", if_valid, 1'b1);
      chk("t4_pc", if_pc, 32'h200);

      // PC wrap on the RESET_PC=0xFFFFFFFC instance
      end_test();
      mon_en = 1'b0;
      mem_auto = 1'b0;
      release_reset();
      @(negedge clk);
      chk("t5_rst_req", w_req, 1'b0);
      chk("t5_rst_addr", w_addr, 32'hFFFF_FFFC);
      chk("t5_rst_valid", w_if_valid, 1'b0);
      chk("t5_rst_instr", w_if_instr, NOP);
      to_cyc(1);
      @(negedge clk);
      chk("t5_req", w_req, 1'b1);
      chk("t5_addr_top", w_addr, 32'hFFFF_FFFC);
      to_cyc(2);
      w_rvalid = 1'b1; w_rdata = word(32'hFFFF_FFFC);
      @(negedge clk);
      chk("t5_addr_wrapped", w_addr, 32'h0);
      to_cyc(3);
      w_rvalid = 1'b0;
      @(negedge clk);
      chk("t5_valid", w_if_valid, 1'b1);
      chk("t5_pc", w_if_pc, 32'hFFFF_FFFC);
      chk("t5_instr", w_if_instr, word(32'hFFFF_FFFC));
      chk("t5_req2", w_req, 1'b1);
      chk("t5_addr2", w_addr, 32'h0);

      // reset mid-operation, then a late response while IDLE/FETCH
      end_test();
      release_reset();
      to_cyc(2);
      man_rvalid = 1'b1; man_rdata = word(32'h0);
      to_cyc(3);
      man_rvalid = 1'b0; stall = 1'b1;
      @(negedge clk);
      chk("t6_pre_valid", if_valid, 1'b1);
      chk("t6_pre_addr", imem_addr, 32'h4);
      to_cyc(4);
      reset = 1'b1;
      #1;
      chk("t6_rst_req", imem_req, 1'b0);
      chk("t6_rst_addr", imem_addr, 32'h0);
      chk("t6_rst_valid", if_valid, 1'b0);
      chk("t6_rst_pc", if_pc, 32'h0);
      chk("t6_rst_instr", if_instr, NOP);
      @(posedge clk);
      #1 reset = 1'b0;
      stall = 1'b0; man_rvalid = 1'b1; man_rdata = JUNK;
      cur = 0;
      @(negedge clk);
      chk("t6_idle_req", imem_req, 1'b0);
      to_cyc(1);
      @(negedge clk);
      chk("t6_req", imem_req, 1'b1);
      chk("t6_req_addr", imem_addr, 32'h0);
      to_cyc(2);
      man_rvalid = 1'b0;
      @(negedge clk);
      chk("t6_late_ignored", if_valid, 1'b0);
      chk("t6_wait_addr", imem_addr, 32'h4);
      to_cyc(3);
      man_rvalid = 1'b1; man_rdata = word(32'h0);
      to_cyc(4);
      man_rvalid = 1'b0;
      @(negedge clk);
      chk("t6_valid", if_valid, 1'b1);
      chk("t6_pc", if_pc, 32'h0);
      chk("t6_instr", if_instr, word(32'h0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
